// File: rtl/ode_io_pkg.sv
// Shared definitions for the ODE solver IO path: RAM address map, bus width and
// the receiver FSM state type.
package ode_io_pkg;

  localparam int unsigned BUS_WIDTH             = 32;
  localparam int unsigned NUMBER_OF_T_ADDRESS   = 1;
  localparam int unsigned NUMBER_OF_X_ADDRESS   = 2;
  localparam int unsigned STARTING_OF_T_ADDRESS = 3;
  localparam int unsigned STARTING_OF_X_ADDRESS = 10;

  // CHK is only reachable when the receiver is built with the checksum option.
  typedef enum logic [2:0] {
    IDLE,
    HDR_T,
    HDR_X,
    T_VAL,
    X_VAL,
    CHK,
    DONE,
    ERR
  } rx_state_t;

endpackage

// File: rtl/beat_assembler.sv
// Packs 32-bit bus beats into one DATA_WIDTH word; first beat is the high part.
// word_valid is combinational with the accepted final beat so the caller can register the write.
module beat_assembler
  import ode_io_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  flush,
  input  logic                  beat_valid,
  input  logic [BUS_WIDTH-1:0]  beat,
  output logic                  word_valid,
  output logic [DATA_WIDTH-1:0] word
);

  generate
    if (DATA_WIDTH > BUS_WIDTH) begin : g_two_beat
      localparam int unsigned HI_W = DATA_WIDTH - BUS_WIDTH;
      logic [HI_W-1:0] hi;
      logic            have_hi;

      always_ff @(posedge CLK) begin
        if (RST || flush) begin
          hi      <= '0;
          have_hi <= 1'b0;
        end else if (beat_valid) begin
          if (have_hi) begin
            have_hi <= 1'b0;
          end else begin
            hi      <= beat[HI_W-1:0];
            have_hi <= 1'b1;
          end
        end
      end

      assign word_valid = beat_valid && have_hi;
      assign word       = {hi, beat};
    end else begin : g_one_beat
      logic unused_sink;
      assign unused_sink = ^{CLK, RST, flush, beat};
      assign word_valid  = beat_valid;
      assign word        = beat[DATA_WIDTH-1:0];
    end
  endgenerate

endmodule

// File: rtl/input_receiver.sv
// CPU-to-RAM loader for the ODE solver: header (N_T, N_X), then per t one T value and N_X X values.
// Optional trailing XOR checksum word when RECEIVER_CHECKSUM_EN is defined.
module input_receiver
  import ode_io_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH         = 13,
  parameter int unsigned DATA_WIDTH            = 64,
  parameter int unsigned NUMBER_OF_T_ADDRESS   = ode_io_pkg::NUMBER_OF_T_ADDRESS,
  parameter int unsigned NUMBER_OF_X_ADDRESS   = ode_io_pkg::NUMBER_OF_X_ADDRESS,
  parameter int unsigned STARTING_OF_T_ADDRESS = ode_io_pkg::STARTING_OF_T_ADDRESS,
  parameter int unsigned STARTING_OF_X_ADDRESS = ode_io_pkg::STARTING_OF_X_ADDRESS
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Receive_Enable,
  input  logic [BUS_WIDTH-1:0]     CPU_Bus,
  input  logic                     Bus_Valid,
  output logic                     Bus_Ready,
  output logic [DATA_WIDTH-1:0]    RAM_Data,
  output logic [ADDRESS_WIDTH-1:0] RAM_Address,
  output logic                     RAM_Write_Enable,
  output logic                     Done_Receiving,
  output logic                     Error
);

  localparam int unsigned AW    = ADDRESS_WIDTH;
  localparam int unsigned MAX_T = STARTING_OF_X_ADDRESS - STARTING_OF_T_ADDRESS;
  localparam logic [2*AW:0] ADDR_SPAN = (2*AW+1)'(1) << AW;

  rx_state_t state, state_n;

  logic                  word_valid;
  logic [DATA_WIDTH-1:0] word;
  logic [AW-1:0]         n_t, n_x, t_cnt, x_cnt;

  logic                wr_req;
  logic [AW-1:0]       wr_addr;

  beat_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
    .CLK        (CLK),
    .RST        (RST),
    .flush      (!Receive_Enable),
    .beat_valid (Bus_Valid && Bus_Ready),
    .beat       (CPU_Bus),
    .word_valid (word_valid),
    .word       (word)
  );

  assign Bus_Ready = Receive_Enable &&
                     (state == HDR_T || state == HDR_X || state == T_VAL ||
                      state == X_VAL || state == CHK);
  assign Done_Receiving = (state == DONE);
  assign Error          = (state == ERR);

  // Header checks: the full incoming word is range-checked before truncating to counter width.
  logic [DATA_WIDTH+AW-1:0] word_ext;
  logic [AW-1:0]            word_lo;
  logic                     word_hi_zero;
  logic [2*AW-1:0]          hdr_prod;
  logic [2*AW:0]            hdr_end;
  logic                     nt_bad, nx_bad;

  assign word_ext     = {{AW{1'b0}}, word};
  assign word_lo      = word_ext[AW-1:0];
  assign word_hi_zero = (word_ext[DATA_WIDTH+AW-1:AW] == '0);
  assign hdr_prod     = {{AW{1'b0}}, n_t} * {{AW{1'b0}}, word_lo};
  assign hdr_end      = (2*AW+1)'(STARTING_OF_X_ADDRESS) + {1'b0, hdr_prod};
  assign nt_bad       = (word == '0) || (word > DATA_WIDTH'(MAX_T));
  assign nx_bad       = (word == '0) || !word_hi_zero || (hdr_end > ADDR_SPAN);

  logic [AW:0] x_prod, x_addr_w, t_addr_w;
  logic        last_x, last_t;

  assign x_prod   = {1'b0, n_x} * {1'b0, t_cnt};
  assign x_addr_w = (AW+1)'(STARTING_OF_X_ADDRESS) + {1'b0, x_cnt} + x_prod;
  assign t_addr_w = (AW+1)'(STARTING_OF_T_ADDRESS) + {1'b0, t_cnt};
  assign last_x   = (x_cnt == n_x - AW'(1));
  assign last_t   = (t_cnt == n_t - AW'(1));

`ifdef RECEIVER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum;
`endif

  always_comb begin
    state_n = state;
    wr_req  = 1'b0;
    wr_addr = '0;
    case (state)
      IDLE: if (Receive_Enable) state_n = HDR_T;
      HDR_T: if (word_valid) begin
        if (nt_bad) state_n = ERR;
        else begin
          wr_req  = 1'b1;
          wr_addr = AW'(NUMBER_OF_T_ADDRESS);
          state_n = HDR_X;
        end
      end
      HDR_X: if (word_valid) begin
        if (nx_bad) state_n = ERR;
        else begin
          wr_req  = 1'b1;
          wr_addr = AW'(NUMBER_OF_X_ADDRESS);
          state_n = T_VAL;
        end
      end
      T_VAL: if (word_valid) begin
        wr_req  = 1'b1;
        wr_addr = t_addr_w[AW-1:0];
        state_n = X_VAL;
      end
      X_VAL: if (word_valid) begin
        wr_req  = 1'b1;
        wr_addr = x_addr_w[AW-1:0];
        if (last_x && last_t) begin
`ifdef RECEIVER_CHECKSUM_EN
          state_n = CHK;
`else
          state_n = DONE;
`endif
        end else if (last_x) begin
          state_n = T_VAL;
        end
      end
`ifdef RECEIVER_CHECKSUM_EN
      CHK: if (word_valid) state_n = (word == csum) ? DONE : ERR;
`endif
      DONE, ERR: ;
      default: state_n = IDLE;
    endcase
    // Enable low aborts any session; DONE/ERR also leave through here.
    if (!Receive_Enable) state_n = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state            <= IDLE;
      n_t              <= '0;
      n_x              <= '0;
      t_cnt            <= '0;
      x_cnt            <= '0;
      RAM_Write_Enable <= 1'b0;
      RAM_Address      <= '0;
      RAM_Data         <= '0;
`ifdef RECEIVER_CHECKSUM_EN
      csum             <= '0;
`endif
    end else begin
      state            <= state_n;
      RAM_Write_Enable <= wr_req;
      if (wr_req) begin
        RAM_Address <= wr_addr;
        RAM_Data    <= word;
      end
      if (state == IDLE) begin
        n_t   <= '0;
        n_x   <= '0;
        t_cnt <= '0;
        x_cnt <= '0;
`ifdef RECEIVER_CHECKSUM_EN
        csum  <= '0;
`endif
      end else if (wr_req) begin
`ifdef RECEIVER_CHECKSUM_EN
        csum <= csum ^ word;
`endif
        case (state)
          HDR_T: n_t <= word_lo;
          HDR_X: n_x <= word_lo;
          X_VAL: begin
            if (last_x) begin
              x_cnt <= '0;
              t_cnt <= t_cnt + AW'(1);
            end else begin
              x_cnt <= x_cnt + AW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_input_receiver.sv
// Self-checking bench for input_receiver: header table, directed corner sequences and
// randomized sessions against a stream-level reference model.
module tb_input_receiver;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Receive_Enable;
  logic [31:0] CPU_Bus;
  logic        Bus_Valid;
  logic        Bus_Ready;
  logic [63:0] RAM_Data;
  logic [12:0] RAM_Address;
  logic        RAM_Write_Enable;
  logic        Done_Receiving;
  logic        Error;

  input_receiver #(.ADDRESS_WIDTH(13), .DATA_WIDTH(64)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .Receive_Enable   (Receive_Enable),
    .CPU_Bus          (CPU_Bus),
    .Bus_Valid        (Bus_Valid),
    .Bus_Ready        (Bus_Ready),
    .RAM_Data         (RAM_Data),
    .RAM_Address      (RAM_Address),
    .RAM_Write_Enable (RAM_Write_Enable),
    .Done_Receiving   (Done_Receiving),
    .Error            (Error)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct { int cyc; int addr; logic [63:0] data; } wr_t;
  typedef struct { int idx; int addr; logic [63:0] data; } ew_t;
  wr_t wq[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    wr_t w;
    if (RAM_Write_Enable === 1'b1) begin
      w.cyc = cyc; w.addr = int'(RAM_Address); w.data = RAM_Data;
      wq.push_back(w);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ew_t mk(input int idx, input int addr, input logic [63:0] d);
    ew_t e;
    e.idx = idx; e.addr = addr; e.data = d;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send_beat(input logic [31:0] b, input bit gap, output int acc);
    int n;
    n = 0;
    CPU_Bus = b; Bus_Valid = 1'b1;
    while (Bus_Ready !== 1'b1 && n < 40) begin @(negedge CLK); n++; end
    if (Bus_Ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL beat_timeout: got Bus_Ready=%b expected 1", Bus_Ready);
      Bus_Valid = 1'b0; acc = -1;
      return;
    end
    @(negedge CLK);
    acc = cyc;
    Bus_Valid = 1'b0;
    if (gap) @(negedge CLK);
  endtask

  task automatic send_word(input logic [63:0] w, input bit gap, output int acc);
    int a;
    send_beat(w[63:32], gap, a);
    send_beat(w[31:0], gap, acc);
  endtask

  task automatic run_session(input logic [63:0] s_in[$], input bit gap, input bit bad_csum,
                             input string tag);
    ew_t         ew[$];
    int          accq[$];
    logic [63:0] s[$];
    logic [63:0] nt, nx, x;
    int          n_use, k, acc;
    bit          exp_err;
    s = s_in; nt = s[0]; nx = s[1]; x = '0; exp_err = 0; k = 0;
    if (nt == 0 || nt > 7) begin
      exp_err = 1; n_use = 1;
    end else begin
      ew.push_back(mk(0, 1, nt));
      if (nx == 0 || nx >= 8192 || 10 + nx * nt - 1 >= 8192) begin
        exp_err = 1; n_use = 2;
      end else begin
        ew.push_back(mk(1, 2, nx));
        k = 2;
        for (int t = 0; t < int'(nt); t++) begin
          ew.push_back(mk(k, 3 + t, s[k])); k++;
          for (int xi = 0; xi < int'(nx); xi++) begin
            ew.push_back(mk(k, 10 + xi + int'(nx) * t, s[k])); k++;
          end
        end
        n_use = k;
`ifdef RECEIVER_CHECKSUM_EN
        foreach (ew[i]) x ^= ew[i].data;
        s.insert(k, bad_csum ? (x ^ 64'd1) : x);
        exp_err = bad_csum;
        n_use = k + 1;
`endif
      end
    end
    wq.delete();
    Receive_Enable = 1'b1;
    for (int i = 0; i < n_use; i++) begin
      send_word(s[i], gap, acc);
      accq.push_back(acc);
    end
    repeat (2) @(negedge CLK);
    chk({tag, "_nwrites"}, wq.size(), ew.size());
    for (int i = 0; i < ew.size() && i < wq.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wq[i].addr, ew[i].addr);
      chk($sformatf("%s_data%0d", tag, i), wq[i].data, ew[i].data);
      chk($sformatf("%s_lat%0d", tag, i), wq[i].cyc, accq[ew[i].idx]);
    end
    chk({tag, "_done"}, Done_Receiving, !exp_err);
    chk({tag, "_error"}, Error, exp_err);
    chk({tag, "_ready_end"}, Bus_Ready, 0);
    Receive_Enable = 1'b0;
    @(negedge CLK);
    chk({tag, "_done_clr"}, Done_Receiving, 0);
    chk({tag, "_error_clr"}, Error, 0);
    if (bad_csum) x = '0;
  endtask

  function automatic void build_case1(output logic [63:0] s[$]);
    s = {};
    s.push_back(2); s.push_back(3);
    s.push_back(5); s.push_back(1); s.push_back(2); s.push_back(3);
    s.push_back(6); s.push_back(4); s.push_back(5); s.push_back(6);
  endfunction

  typedef struct { logic [63:0] nt; logic [63:0] nx; bit err; int nwr; } hv_t;

  initial begin
    hv_t         hv[8];
    logic [63:0] s[$];
    int          case1_addr[10];
    int          acc, nt, nx;

    hv = '{ '{64'd0, 64'd3, 1'b1, 0}, '{64'd8, 64'd2, 1'b1, 0},
            '{64'd7, 64'd1168, 1'b0, 2}, '{64'd7, 64'd1169, 1'b1, 1},
            '{64'd1, 64'd8182, 1'b0, 2}, '{64'd1, 64'd8183, 1'b1, 1},
            '{64'd2, 64'd0, 1'b1, 1}, '{64'd3, 64'h1_0000_0002, 1'b1, 1} };
    case1_addr = '{1, 2, 3, 10, 11, 12, 4, 13, 14, 15};

    RST = 1'b1; Receive_Enable = 1'b0; Bus_Valid = 1'b0; CPU_Bus = '0;
    repeat (3) @(negedge CLK);
    chk("rst_we", RAM_Write_Enable, 0);
    chk("rst_addr", RAM_Address, 0);
    chk("rst_data", RAM_Data, 0);
    chk("rst_done", Done_Receiving, 0);
    chk("rst_error", Error, 0);
    chk("rst_ready", Bus_Ready, 0);
    RST = 1'b0;

    // Valid beats while disabled are ignored.
    wq.delete();
    CPU_Bus = 32'hDEAD_BEEF; Bus_Valid = 1'b1;
    repeat (4) @(negedge CLK);
    chk("idle_ready", Bus_Ready, 0);
    chk("idle_nwrites", wq.size(), 0);
    Bus_Valid = 1'b0;

    // Header boundary table.
    foreach (hv[i]) begin
      wq.delete();
      Receive_Enable = 1'b1;
      send_word(hv[i].nt, 1'b0, acc);
      if (hv[i].nwr > 0) send_word(hv[i].nx, 1'b0, acc);
      @(negedge CLK);
      chk($sformatf("hdr%0d_error", i), Error, hv[i].err);
      chk($sformatf("hdr%0d_nwrites", i), wq.size(), hv[i].nwr);
      chk($sformatf("hdr%0d_ready", i), Bus_Ready, !hv[i].err);
      if (wq.size() > 0) chk($sformatf("hdr%0d_ntdata", i), wq[0].data, hv[i].nt);
      Receive_Enable = 1'b0;
      @(negedge CLK);
      chk($sformatf("hdr%0d_error_clr", i), Error, 0);
      chk($sformatf("hdr%0d_ready_clr", i), Bus_Ready, 0);
    end

    // Reference session, back-to-back and with Bus_Valid toggling.
    for (int g = 0; g < 2; g++) begin
      build_case1(s);
      run_session(s, g[0], 1'b0, g == 0 ? "case1" : "case1_gap");
      for (int i = 0; i < 10 && i < wq.size(); i++)
        chk($sformatf("case1_map%0d_g%0d", i, g), wq[i].addr, case1_addr[i]);
    end

    // Enable dropped after the high beat of T[0].
    wq.delete();
    Receive_Enable = 1'b1;
    send_word(64'd2, 1'b0, acc);
    send_word(64'd3, 1'b0, acc);
    send_beat(32'h1234_5678, 1'b0, acc);
    Receive_Enable = 1'b0;
    repeat (2) @(negedge CLK);
    chk("drop_nwrites", wq.size(), 2);
    chk("drop_ready", Bus_Ready, 0);
    build_case1(s);
    run_session(s, 1'b0, 1'b0, "drop_restart");

    // Reset in the middle of X_VAL with half an X word assembled.
    Receive_Enable = 1'b1;
    send_word(64'd2, 1'b0, acc);
    send_word(64'd3, 1'b0, acc);
    send_word(64'd5, 1'b0, acc);
    send_word(64'hAAAA_0000_0000_0001, 1'b0, acc);
    send_beat(32'hFFFF_FFFF, 1'b0, acc);
    RST = 1'b1;
    @(negedge CLK);
    chk("mrst_we", RAM_Write_Enable, 0);
    chk("mrst_addr", RAM_Address, 0);
    chk("mrst_data", RAM_Data, 0);
    chk("mrst_done", Done_Receiving, 0);
    chk("mrst_error", Error, 0);
    chk("mrst_ready", Bus_Ready, 0);
    RST = 1'b0;
    build_case1(s);
    run_session(s, 1'b0, 1'b0, "mrst_fresh");

`ifdef RECEIVER_CHECKSUM_EN
    build_case1(s);
    run_session(s, 1'b0, 1'b0, "csum_ok");
    build_case1(s);
    run_session(s, 1'b1, 1'b1, "csum_bad");
`endif

    // Randomized sessions.
    for (int r = 0; r < 8; r++) begin
      nt = $urandom_range(1, 7);
      nx = $urandom_range(1, 4);
      s = {};
      s.push_back(64'(nt)); s.push_back(64'(nx));
      for (int i = 0; i < nt * (nx + 1); i++) s.push_back({$urandom, $urandom});
      run_session(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
